// File: rtl/pipe_pattern_pkg.sv
// ============================================================================
// pipe_pattern_pkg : mode encodings, default seed and LFSR taps
// Rev 1.0
// ============================================================================
`default_nettype none

package pipe_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_COUNTER = 2'd0,
    MODE_LFSR    = 2'd1,
    MODE_WALK    = 2'd2,
    MODE_ALT     = 2'd3
  } mode_e;

  localparam logic [31:0] c_default_seed = 32'h0D0C0B0A;

  localparam int c_tap_a = 31;
  localparam int c_tap_b = 21;
  localparam int c_tap_c = 1;
  localparam int c_tap_d = 0;

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {l[30:0], l[c_tap_a] ^ l[c_tap_b] ^ l[c_tap_c] ^ l[c_tap_d]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_pattern_engine_if.sv
// ============================================================================
// pipe_pattern_engine_if : host pipe-in / pipe-out bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface pipe_pattern_engine_if #(
  parameter int DATA_W = 16
);
  logic              pipe_in_write;
  logic [DATA_W-1:0] pipe_in_data;
  logic              pipe_in_ready;
  logic              pipe_out_read;
  logic [DATA_W-1:0] pipe_out_data;
  logic              pipe_out_valid;

  modport master (
    output pipe_in_write, pipe_in_data, pipe_out_read,
    input  pipe_in_ready, pipe_out_data, pipe_out_valid
  );

  modport slave (
    input  pipe_in_write, pipe_in_data, pipe_out_read,
    output pipe_in_ready, pipe_out_data, pipe_out_valid
  );
endinterface

`default_nettype wire

// File: rtl/pattern_gen.sv
// ============================================================================
// pattern_gen : registered test-pattern word generator (counter/LFSR/walk/alt)
// Rev 1.0
// ============================================================================
`default_nettype none

module pattern_gen
  import pipe_pattern_pkg::*;
#(
  parameter int          DATA_W = 16,
  parameter logic [31:0] SEED   = c_default_seed
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              load,
  input  wire logic              advance,
  input  wire mode_e             mode,
  output logic      [DATA_W-1:0] word
);

  mode_e             r_mode;
  logic [31:0]       r_lfsr;
  logic [DATA_W-1:0] r_word;

  logic [31:0]       w_lfsr_next;
  logic [DATA_W-1:0] w_alt_even;
  logic [DATA_W-1:0] w_first;
  logic [DATA_W-1:0] w_next;

  assign w_lfsr_next = lfsr_next(r_lfsr);
  assign w_alt_even  = {(DATA_W/2){2'b10}};

  always_comb begin
    w_first = DATA_W'(1);
    case (mode)
      MODE_COUNTER: w_first = DATA_W'(1);
      MODE_LFSR:    w_first = SEED[DATA_W-1:0];
      MODE_WALK:    w_first = DATA_W'(1);
      MODE_ALT:     w_first = w_alt_even;
      default:      w_first = DATA_W'(1);
    endcase
  end

  // Walking-one is a left rotate, so it wraps from the MSB back to bit 0.
  always_comb begin
    w_next = r_word + DATA_W'(1);
    case (r_mode)
      MODE_COUNTER: w_next = r_word + DATA_W'(1);
      MODE_LFSR:    w_next = w_lfsr_next[DATA_W-1:0];
      MODE_WALK:    w_next = {r_word[DATA_W-2:0], r_word[DATA_W-1]};
      MODE_ALT:     w_next = ~r_word;
      default:      w_next = r_word + DATA_W'(1);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode <= MODE_COUNTER;
      r_lfsr <= SEED;
      r_word <= DATA_W'(1);
    end else if (load) begin
      r_mode <= mode;
      r_lfsr <= SEED;
      r_word <= w_first;
    end else if (advance) begin
      r_lfsr <= w_lfsr_next;
      r_word <= w_next;
    end
  end

  assign word = r_word;

endmodule

`default_nettype wire

// File: rtl/pipe_pattern_engine.sv
// ============================================================================
// pipe_pattern_engine : pipe test-pattern source and checker with throttling
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_pattern_engine
  import pipe_pattern_pkg::*;
#(
  parameter int          DATA_W = 16,
  parameter int          CNT_W  = 16,
  parameter logic [31:0] SEED   = c_default_seed
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              restart,
  input  wire logic [1:0]        mode,
  input  wire logic [7:0]        throttle,
  pipe_pattern_engine_if.slave   pipe,
  output logic      [CNT_W-1:0]  error_count,
  output logic      [31:0]       in_word_count,
  output logic      [31:0]       out_word_count,
  output logic                   first_err_valid,
  output logic      [31:0]       first_err_index,
  output logic      [DATA_W-1:0] first_err_expected,
  output logic      [DATA_W-1:0] first_err_received
);

  logic              w_write;
  logic              w_read;
  logic              w_mismatch;
  logic [DATA_W-1:0] w_out_word;
  logic [DATA_W-1:0] w_exp_word;

  logic [7:0]        r_rot;
  logic [CNT_W-1:0]  r_err_cnt;
  logic [31:0]       r_in_cnt;
  logic [31:0]       r_out_cnt;
  logic              r_fe_valid;
  logic [31:0]       r_fe_index;
  logic [DATA_W-1:0] r_fe_exp;
  logic [DATA_W-1:0] r_fe_rcv;

  // Restart owns the cycle: any strobe in the same cycle is dropped.
  assign w_write    = pipe.pipe_in_write & ~restart;
  assign w_read     = pipe.pipe_out_read & ~restart;
  assign w_mismatch = w_write && (pipe.pipe_in_data != w_exp_word);

  pattern_gen #(.DATA_W(DATA_W), .SEED(SEED)) u_gen_out (
    .clk     (clk),
    .reset   (reset),
    .load    (restart),
    .advance (w_read),
    .mode    (mode_e'(mode)),
    .word    (w_out_word)
  );

  pattern_gen #(.DATA_W(DATA_W), .SEED(SEED)) u_gen_in (
    .clk     (clk),
    .reset   (reset),
    .load    (restart),
    .advance (w_write),
    .mode    (mode_e'(mode)),
    .word    (w_exp_word)
  );

  // The duty mask is consumed LSB first, one bit per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rot      <= 8'hFF;
      r_err_cnt  <= '0;
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      r_fe_valid <= 1'b0;
      r_fe_index <= '0;
      r_fe_exp   <= '0;
      r_fe_rcv   <= '0;
    end else if (restart) begin
      r_rot      <= (throttle == 8'h00) ? 8'hFF : throttle;
      r_err_cnt  <= '0;
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      r_fe_valid <= 1'b0;
      r_fe_index <= '0;
      r_fe_exp   <= '0;
      r_fe_rcv   <= '0;
    end else begin
      r_rot <= {r_rot[0], r_rot[7:1]};
      if (w_read)
        r_out_cnt <= r_out_cnt + 32'd1;
      if (w_write)
        r_in_cnt <= r_in_cnt + 32'd1;
      if (w_mismatch) begin
        if (r_err_cnt != {CNT_W{1'b1}})
          r_err_cnt <= r_err_cnt + CNT_W'(1);
        if (!r_fe_valid) begin
          r_fe_valid <= 1'b1;
          r_fe_index <= r_in_cnt;
          r_fe_exp   <= w_exp_word;
          r_fe_rcv   <= pipe.pipe_in_data;
        end
      end
    end
  end

  assign pipe.pipe_out_data  = w_out_word;
  assign pipe.pipe_in_ready  = r_rot[0];
  assign pipe.pipe_out_valid = r_rot[0];

  assign error_count        = r_err_cnt;
  assign in_word_count      = r_in_cnt;
  assign out_word_count     = r_out_cnt;
  assign first_err_valid    = r_fe_valid;
  assign first_err_index    = r_fe_index;
  assign first_err_expected = r_fe_exp;
  assign first_err_received = r_fe_rcv;

endmodule

`default_nettype wire
